// File: rtl/dfe_mon_pkg.sv
// Shared types and width helpers for the DFE stage monitor.
// Imported by the monitor top and its snapshot RAM.
package dfe_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } mon_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'b00,
    TRIG_OVF = 2'b01,
    TRIG_UDF = 2'b10,
    TRIG_ANY = 2'b11
  } trig_mode_e;

  function automatic int sel_w(input int n_stage);
    return $clog2(n_stage + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dfe_mon_ram.sv
// Snapshot buffer: one write port, one registered read port.
// Storage is not reset; only the read register is.
module dfe_mon_ram
  import dfe_mon_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dfe_stage_monitor.sv
// DFE stage monitor: live tap select, sticky flags, event
// counter and triggered snapshot capture with read-back.
module dfe_stage_monitor
  import dfe_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_STAGE    = 5,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16,
  localparam int SEL_W     = sel_w(N_STAGE),
  localparam int FW        = ptr_w(DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_STAGE-1:0][DATA_WIDTH-1:0]   stage_data,
  input  logic [N_STAGE-1:0]                   stage_valid,
  input  logic [N_STAGE-1:0]                   stage_ovf,
  input  logic [N_STAGE-1:0]                   stage_udf,
  input  logic [SEL_W-1:0]                     sel,
  input  logic [1:0]                           trig_mode,
  input  logic                                 arm,
  input  logic                                 abort,
  input  logic                                 clear_flags,
  input  logic                                 rd_en,
  output logic [DATA_WIDTH-1:0]                mon_out,
  output logic                                 mon_valid,
  output logic [N_STAGE-1:0]                   sticky_ovf,
  output logic [N_STAGE-1:0]                   sticky_udf,
  output logic [CNT_WIDTH-1:0]                 evt_cnt,
  output logic                                 busy,
  output logic                                 done,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_valid,
  output logic [FW-1:0]                        fill
);

  localparam int AW = ptr_w(DEPTH);

  mon_state_e                state_d, state_q;
  trig_mode_e                mode_d, mode_q;
  logic [SEL_W-1:0]          sel_d, sel_q;
  logic [AW-1:0]             wptr_d, wptr_q;
  logic [FW-1:0]             rptr_d, rptr_q;
  logic [FW-1:0]             fill_d, fill_q;
  logic                      done_d, done_q;
  logic                      rd_valid_d, rd_valid_q;
  logic [DATA_WIDTH-1:0]     mon_out_d, mon_out_q;
  logic                      mon_valid_d, mon_valid_q;
  logic [N_STAGE-1:0]        sticky_ovf_d, sticky_ovf_q;
  logic [N_STAGE-1:0]        sticky_udf_d, sticky_udf_q;
  logic [CNT_WIDTH-1:0]      evt_cnt_d, evt_cnt_q;

  logic                      sel_ok, sel_ovf, sel_udf, evt;
  logic                      cap_valid, cap_ovf, cap_udf, hit;
  logic [DATA_WIDTH-1:0]     cap_data;
  logic                      we, re;

  // Live taps follow sel; capture taps follow the latched sel_q.
  always_comb begin
    sel_ok      = sel < SEL_W'(N_STAGE);
    mon_out_d   = '0;
    mon_valid_d = 1'b0;
    sel_ovf     = 1'b0;
    sel_udf     = 1'b0;
    cap_valid   = 1'b0;
    cap_data    = '0;
    cap_ovf     = 1'b0;
    cap_udf     = 1'b0;
    for (int i = 0; i < N_STAGE; i++) begin
      if (sel == SEL_W'(i)) begin
        mon_out_d   = stage_data[i];
        mon_valid_d = stage_valid[i];
        sel_ovf     = stage_ovf[i];
        sel_udf     = stage_udf[i];
      end
      if (sel_q == SEL_W'(i)) begin
        cap_valid = stage_valid[i];
        cap_data  = stage_data[i];
        cap_ovf   = stage_ovf[i];
        cap_udf   = stage_udf[i];
      end
    end
  end

  always_comb begin
    evt          = sel_ovf | sel_udf;
    sticky_ovf_d = sticky_ovf_q | stage_ovf;
    sticky_udf_d = sticky_udf_q | stage_udf;
    evt_cnt_d    = evt_cnt_q;
    if (evt && !(&evt_cnt_q)) evt_cnt_d = evt_cnt_q + CNT_WIDTH'(1);
    if (clear_flags) begin
      sticky_ovf_d = stage_ovf;
      sticky_udf_d = stage_udf;
      evt_cnt_d    = CNT_WIDTH'(evt);
    end
  end

  always_comb begin
    hit = 1'b0;
    unique case (mode_q)
      TRIG_IMM: hit = 1'b1;
      TRIG_OVF: hit = cap_ovf;
      TRIG_UDF: hit = cap_udf;
      TRIG_ANY: hit = cap_ovf | cap_udf;
      default:  hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fill_d     = fill_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    if (abort) begin
      state_d = IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      fill_d  = '0;
    end else if ((state_q == IDLE || state_q == DONE) && arm && sel_ok) begin
      state_d = ARMED;
      sel_d   = sel;
      mode_d  = trig_mode_e'(trig_mode);
      wptr_d  = '0;
      rptr_d  = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (cap_valid && hit) begin
            we      = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            fill_d  = fill_q + FW'(1);
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_valid) begin
            we     = 1'b1;
            wptr_d = wptr_q + AW'(1);
            fill_d = fill_q + FW'(1);
            if (fill_q == FW'(DEPTH - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          if (rd_en && rptr_q < fill_q) begin
            re         = 1'b1;
            rd_valid_d = 1'b1;
            rptr_d     = rptr_q + FW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= TRIG_IMM;
      sel_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fill_q       <= '0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      mon_out_q    <= '0;
      mon_valid_q  <= 1'b0;
      sticky_ovf_q <= '0;
      sticky_udf_q <= '0;
      evt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fill_q       <= fill_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      mon_out_q    <= mon_out_d;
      mon_valid_q  <= mon_valid_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_udf_q <= sticky_udf_d;
      evt_cnt_q    <= evt_cnt_d;
    end
  end

  dfe_mon_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wptr_q),
    .wdata (cap_data),
    .re    (re),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign mon_out    = mon_out_q;
  assign mon_valid  = mon_valid_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_udf = sticky_udf_q;
  assign evt_cnt    = evt_cnt_q;
  assign busy       = (state_q == ARMED) || (state_q == CAPTURE);
  assign done       = done_q;
  assign rd_valid   = rd_valid_q;
  assign fill       = fill_q;

endmodule

// File: tb/tb_dfe_stage_monitor.sv
// Directed bench for dfe_stage_monitor: live select, capture,
// triggers, sticky flags, counter saturation, abort and reset.
module tb_dfe_stage_monitor;

  logic             clk;
  logic             rst_n;
  logic [4:0][15:0] stage_data;
  logic [4:0]       stage_valid;
  logic [4:0]       stage_ovf;
  logic [4:0]       stage_udf;
  logic [2:0]       sel;
  logic [1:0]       trig_mode;
  logic             arm, abort, clear_flags, rd_en;

  logic [15:0]      mon_out, rd_data, s_mon_out, s_rd_data;
  logic             mon_valid, busy, done, rd_valid;
  logic             s_mon_valid, s_busy, s_done, s_rd_valid;
  logic [4:0]       sticky_ovf, sticky_udf, s_sticky_ovf, s_sticky_udf;
  logic [15:0]      evt_cnt;
  logic [3:0]       s_evt_cnt;
  logic [6:0]       fill, s_fill;

  int checks = 0;
  int errs   = 0;
  int nd;

  dfe_stage_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .stage_data(stage_data),
    .stage_valid(stage_valid), .stage_ovf(stage_ovf),
    .stage_udf(stage_udf), .sel(sel), .trig_mode(trig_mode),
    .arm(arm), .abort(abort), .clear_flags(clear_flags),
    .rd_en(rd_en), .mon_out(mon_out), .mon_valid(mon_valid),
    .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf),
    .evt_cnt(evt_cnt), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .fill(fill)
  );

  dfe_stage_monitor #(.CNT_WIDTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .stage_data(stage_data),
    .stage_valid(stage_valid), .stage_ovf(stage_ovf),
    .stage_udf(stage_udf), .sel(sel), .trig_mode(trig_mode),
    .arm(arm), .abort(abort), .clear_flags(clear_flags),
    .rd_en(rd_en), .mon_out(s_mon_out), .mon_valid(s_mon_valid),
    .sticky_ovf(s_sticky_ovf), .sticky_udf(s_sticky_udf),
    .evt_cnt(s_evt_cnt), .busy(s_busy), .done(s_done),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .fill(s_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [15:0] d);
    stage_valid    = '0;
    stage_valid[s] = 1'b1;
    stage_data[s]  = d;
    step();
    stage_valid    = '0;
  endtask

  initial begin
    rst_n = 1'b0; stage_data = '0; stage_valid = '0;
    stage_ovf = '0; stage_udf = '0; sel = '0; trig_mode = '0;
    arm = 0; abort = 0; clear_flags = 0; rd_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mon_out", 32'(mon_out), 0);
    chk("rst_mon_valid", 32'(mon_valid), 0);
    chk("rst_sticky_ovf", 32'(sticky_ovf), 0);
    chk("rst_evt_cnt", 32'(evt_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_fill", 32'(fill), 0);
    rst_n = 1'b1;
    step();

    // live select
    sel = 3'd2; stage_valid = 5'b00100; stage_data[2] = 16'h7FF0;
    step();
    chk("live_mon_out", 32'(mon_out), 32'h7FF0);
    chk("live_mon_valid", 32'(mon_valid), 1);
    sel = 3'd7;
    step();
    chk("live_sel7_out", 32'(mon_out), 0);
    chk("live_sel7_valid", 32'(mon_valid), 0);
    stage_valid = '0; stage_data = '0;

    // immediate capture on stage 0
    sel = 3'd0; trig_mode = 2'b00; arm = 1;
    step();
    arm = 0;
    chk("imm_busy", 32'(busy), 1);
    chk("imm_fill0", 32'(fill), 0);
    for (int i = 0; i < 64; i++) begin
      push(0, 16'(i));
      if (i == 62) begin
        chk("imm_fill63", 32'(fill), 63);
        chk("imm_nodone63", 32'(done), 0);
      end
    end
    chk("imm_done", 32'(done), 1);
    chk("imm_busy_drop", 32'(busy), 0);
    chk("imm_fill64", 32'(fill), 64);
    step();
    chk("imm_done_pulse", 32'(done), 0);
    rd_en = 1;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("imm_rd_valid", 32'(rd_valid), 1);
      chk("imm_rd_data", 32'(rd_data), 32'(i));
    end
    step();
    chk("imm_rd65_valid", 32'(rd_valid), 0);
    rd_en = 0;

    // overflow trigger on stage 4
    sel = 3'd4; trig_mode = 2'b01; arm = 1;
    step();
    arm = 0;
    for (int i = 0; i < 3; i++) push(4, 16'h0A00 + 16'(i));
    chk("ovf_still_armed", 32'(busy), 1);
    chk("ovf_fill0", 32'(fill), 0);
    stage_ovf[4] = 1'b1;
    push(4, 16'h8000);
    stage_ovf = '0;
    chk("ovf_fill1", 32'(fill), 1);
    chk("ovf_sticky", 32'(sticky_ovf), 32'h10);
    chk("ovf_evt", 32'(evt_cnt), 1);
    for (int i = 0; i < 63; i++) push(4, 16'h1000 + 16'(i));
    chk("ovf_done", 32'(done), 1);
    rd_en = 1;
    step();
    chk("ovf_entry0", 32'(rd_data), 32'h8000);
    step();
    chk("ovf_entry1", 32'(rd_data), 32'h1000);
    rd_en = 0;
    clear_flags = 1;
    step();
    clear_flags = 0;
    chk("clr_sticky", 32'(sticky_ovf), 0);
    chk("clr_evt", 32'(evt_cnt), 0);

    // sticky flags and event counter
    sel = 3'd1;
    for (int k = 0; k < 3; k++) begin
      stage_ovf[1] = 1'b1;
      step();
      stage_ovf = '0;
      step();
    end
    chk("stk_ovf1", 32'(sticky_ovf), 32'h02);
    chk("stk_evt3", 32'(evt_cnt), 3);
    clear_flags = 1; stage_ovf[1] = 1'b1;
    step();
    clear_flags = 0; stage_ovf = '0;
    chk("stk_setwins", 32'(sticky_ovf), 32'h02);
    chk("stk_evt_clr1", 32'(evt_cnt), 1);
    stage_ovf[1] = 1'b1; stage_udf[1] = 1'b1;
    step();
    stage_ovf = '0; stage_udf = '0;
    chk("stk_both_once", 32'(evt_cnt), 2);
    chk("stk_udf1", 32'(sticky_udf), 32'h02);
    stage_ovf[3] = 1'b1;
    step();
    stage_ovf = '0;
    chk("stk_ovf3", 32'(sticky_ovf), 32'h0A);
    chk("stk_unsel_evt", 32'(evt_cnt), 2);
    clear_flags = 1;
    step();
    clear_flags = 0;
    stage_ovf[1] = 1'b1;
    repeat (20) step();
    stage_ovf = '0;
    chk("cnt_evt20", 32'(evt_cnt), 20);
    chk("cnt_sat4", 32'(s_evt_cnt), 15);

    // abort and arm-in-capture
    sel = 3'd0; trig_mode = 2'b00; arm = 1;
    step();
    arm = 0;
    for (int i = 0; i < 10; i++) push(0, 16'h2000 + 16'(i));
    chk("abt_fill10", 32'(fill), 10);
    sel = 3'd3; arm = 1;
    step();
    arm = 0; sel = 3'd0;
    push(0, 16'h2100);
    chk("abt_arm_ign_fill", 32'(fill), 11);
    chk("abt_arm_ign_busy", 32'(busy), 1);
    rd_en = 1;
    step();
    rd_en = 0;
    chk("abt_rd_in_cap", 32'(rd_valid), 0);
    abort = 1;
    step();
    abort = 0;
    chk("abt_busy", 32'(busy), 0);
    chk("abt_fill", 32'(fill), 0);
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      push(0, 16'h3000 + 16'(i));
      nd += int'(done);
    end
    chk("abt_no_done", 32'(nd), 0);
    chk("abt_idle_fill", 32'(fill), 0);

    // reset mid-capture
    arm = 1;
    step();
    arm = 0;
    for (int i = 0; i < 30; i++) push(0, 16'h4000 + 16'(i));
    chk("rmc_fill30", 32'(fill), 30);
    stage_valid[0] = 1'b1; stage_data[0] = 16'h0005;
    #2 rst_n = 1'b0;
    #1;
    chk("rmc_busy", 32'(busy), 0);
    chk("rmc_fill", 32'(fill), 0);
    chk("rmc_done", 32'(done), 0);
    chk("rmc_evt", 32'(evt_cnt), 0);
    chk("rmc_sticky", 32'(sticky_ovf), 0);
    chk("rmc_rd_data", 32'(rd_data), 0);
    stage_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rmc_mon_valid", 32'(mon_valid), 0);
    arm = 1;
    step();
    arm = 0;
    chk("rmc_rearm_busy", 32'(busy), 1);
    for (int i = 0; i < 64; i++) push(0, 16'h0100 + 16'(i));
    chk("rmc_done2", 32'(done), 1);
    chk("rmc_fill64", 32'(fill), 64);
    rd_en = 1;
    step();
    chk("rmc_rd0", 32'(rd_data), 32'h0100);
    step();
    chk("rmc_rd1", 32'(rd_data), 32'h0101);
    rd_en = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
